// File: rtl/array_arbiter2_pkg.sv
// Shared definitions for the two-client Array channel arbiter: channel widths,
// FSM state encoding and client identifiers.
package array_arbiter2_pkg;

  localparam int ADDR_N = 8;
  localparam int INT_N  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic CLIENT_A = 1'b0;
  localparam logic CLIENT_B = 1'b1;

endpackage

// File: rtl/array_arbiter2.sv
// Round-robin arbiter letting two Array-channel clients share one memory port;
// a grant is held from request latch until the memory reports completion.
module array_arbiter2
  import array_arbiter2_pkg::*;
#(
  parameter int addrN = ADDR_N,
  parameter int intN  = INT_N
) (
  input  logic             clk,
  input  logic             nrst,

  input  logic [addrN-1:0] a_addr,
  input  logic             a_we,
  input  logic [intN-1:0]  a_di,
  input  logic             a_valid,
  output logic [intN-1:0]  a_do,
  output logic             a_ready,

  input  logic [addrN-1:0] b_addr,
  input  logic             b_we,
  input  logic [intN-1:0]  b_di,
  input  logic             b_valid,
  output logic [intN-1:0]  b_do,
  output logic             b_ready,

  output logic [addrN-1:0] m_addr,
  output logic             m_we,
  output logic [intN-1:0]  m_di,
  output logic             m_valid,
  input  logic [intN-1:0]  m_do,
  input  logic             m_ready
);

  logic [1:0] state;
  logic       prio;
  logic       grant;

  logic       any_req;
  logic       pick;

  // A lone requester always wins; on contention prio breaks the tie.
  always_comb begin
    any_req = a_valid | b_valid;
    pick    = CLIENT_A;
    if (a_valid && (!b_valid || prio == CLIENT_A)) begin
      pick = CLIENT_A;
    end else if (b_valid) begin
      pick = CLIENT_B;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      prio    <= CLIENT_A;
      grant   <= CLIENT_A;
      m_addr  <= '0;
      m_we    <= 1'b0;
      m_di    <= '0;
      m_valid <= 1'b0;
      a_do    <= '0;
      a_ready <= 1'b0;
      b_do    <= '0;
      b_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant   <= pick;
            m_valid <= 1'b1;
            if (pick == CLIENT_A) begin
              m_addr <= a_addr;
              m_we   <= a_we;
              m_di   <= a_di;
            end else begin
              m_addr <= b_addr;
              m_we   <= b_we;
              m_di   <= b_di;
            end
            state <= ST_MEM;
          end
        end

        // Data is captured for writes too so the client always sees m_do.
        ST_MEM: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            prio    <= ~grant;
            if (grant == CLIENT_A) begin
              a_do    <= m_do;
              a_ready <= 1'b1;
            end else begin
              b_do    <= m_do;
              b_ready <= 1'b1;
            end
            state <= ST_RESP;
          end
        end

        // The retiring client still shows valid here, so requests are ignored.
        ST_RESP: begin
          a_ready <= 1'b0;
          b_ready <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          a_ready <= 1'b0;
          b_ready <= 1'b0;
          m_valid <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_arbiter2.sv
// Scoreboard bench for array_arbiter2: directed client traffic against a small
// memory responder; a monitor retires expected responses on every ready pulse.
module tb_array_arbiter2;

  logic       clk;
  logic       nrst;
  logic [7:0] a_addr, b_addr, m_addr;
  logic       a_we, b_we, m_we;
  logic [7:0] a_di, b_di, m_di;
  logic       a_valid, b_valid, m_valid;
  logic [7:0] a_do, b_do, m_do;
  logic       a_ready, b_ready, m_ready;

  typedef struct {
    logic       client;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         tests_run;
  int         tests_failed;
  int         a_pulses;
  int         b_pulses;
  int         mem_delay;
  int         mem_cnt;
  logic [7:0] mem [256];

  array_arbiter2 #(.addrN(8), .intN(8)) dut (
    .clk(clk), .nrst(nrst),
    .a_addr(a_addr), .a_we(a_we), .a_di(a_di), .a_valid(a_valid),
    .a_do(a_do), .a_ready(a_ready),
    .b_addr(b_addr), .b_we(b_we), .b_di(b_di), .b_valid(b_valid),
    .b_do(b_do), .b_ready(b_ready),
    .m_addr(m_addr), .m_we(m_we), .m_di(m_di), .m_valid(m_valid),
    .m_do(m_do), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Memory responder: answers after mem_delay cycles of m_valid, one-cycle ready.
  initial begin
    m_ready = 1'b0;
    m_do    = '0;
    mem_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!nrst) begin
        m_ready = 1'b0;
        mem_cnt = 0;
      end else if (m_ready) begin
        m_ready = 1'b0;
        mem_cnt = 0;
      end else if (m_valid) begin
        mem_cnt++;
        if (mem_cnt >= mem_delay) begin
          if (m_we) mem[m_addr] = m_di;
          m_do    = m_we ? m_di : mem[m_addr];
          m_ready = 1'b1;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Monitor: every ready pulse retires the oldest expected response.
  initial begin
    logic prev_ready;
    exp_t e;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (a_ready || b_ready) begin
        if (a_ready) a_pulses++;
        if (b_ready) b_pulses++;
        check_output("ready_exclusive", {31'b0, a_ready & b_ready}, 32'd0);
        check_output("ready_single_pulse", {31'b0, prev_ready}, 32'd0);
        if (sb.size() == 0) begin
          check_output("unexpected_ready_queue", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check_output("ready_client", {31'b0, b_ready}, {31'b0, e.client});
          check_output("ready_data", {24'b0, b_ready ? b_do : a_do}, {24'b0, e.data});
        end
      end
      prev_ready = a_ready | b_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic expect_resp(input logic client, input logic [7:0] data);
    exp_t e;
    e.client = client;
    e.data   = data;
    sb.push_back(e);
  endtask

  task automatic issue(input logic client, input logic [7:0] addr,
                       input logic we, input logic [7:0] di);
    @(negedge clk);
    if (client == 1'b0) begin
      a_addr = addr; a_we = we; a_di = di; a_valid = 1'b1;
    end else begin
      b_addr = addr; b_we = we; b_di = di; b_valid = 1'b1;
    end
  endtask

  // Waits (bounded) for the client's ready, then drops its valid.
  task automatic finish(input logic client);
    int   n;
    logic rdy;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 60) begin
      @(negedge clk);
      rdy = (client == 1'b0) ? a_ready : b_ready;
      n++;
    end
    check_output(client ? "b_ready_seen" : "a_ready_seen", {31'b0, rdy}, 32'd1);
    if (client == 1'b0) a_valid = 1'b0;
    else                b_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic client, input logic [7:0] addr,
                                input logic we, input logic [7:0] di);
    issue(client, addr, we, di);
    finish(client);
  endtask

  task automatic issue_both(input logic [7:0] aaddr, input logic [7:0] baddr);
    @(negedge clk);
    a_addr = aaddr; a_we = 1'b0; a_di = '0; a_valid = 1'b1;
    b_addr = baddr; b_we = 1'b0; b_di = '0; b_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    a_pulses = 0; b_pulses = 0;
    mem_delay = 1;
    foreach (mem[i]) mem[i] = '0;
    mem[1] = 8'd10; mem[2] = 8'd20; mem[3] = 8'd42;
    nrst = 1'b0;
    a_addr = '0; a_we = 1'b0; a_di = '0; a_valid = 1'b0;
    b_addr = '0; b_we = 1'b0; b_di = '0; b_valid = 1'b0;

    // Reset values
    #12;
    check_output("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check_output("rst_a_ready", {31'b0, a_ready}, 32'd0);
    check_output("rst_b_ready", {31'b0, b_ready}, 32'd0);
    check_output("rst_m_addr", {24'b0, m_addr}, 32'd0);
    check_output("rst_m_we", {31'b0, m_we}, 32'd0);
    check_output("rst_m_di", {24'b0, m_di}, 32'd0);
    check_output("rst_a_do", {24'b0, a_do}, 32'd0);
    check_output("rst_b_do", {24'b0, b_do}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Single read by A
    expect_resp(1'b0, 8'd42);
    issue(1'b0, 8'd3, 1'b0, 8'd0);
    @(negedge clk);
    check_output("read_m_valid", {31'b0, m_valid}, 32'd1);
    check_output("read_m_addr", {24'b0, m_addr}, 32'd3);
    check_output("read_m_we", {31'b0, m_we}, 32'd0);
    finish(1'b0);
    check_output("read_b_ready", {31'b0, b_ready}, 32'd0);
    @(negedge clk);
    check_output("read_a_ready_drop", {31'b0, a_ready}, 32'd0);

    // B writes 5 then reads it back; A's data is untouched
    expect_resp(1'b1, 8'd17);
    issue(1'b1, 8'd5, 1'b1, 8'd17);
    @(negedge clk);
    check_output("write_m_we", {31'b0, m_we}, 32'd1);
    check_output("write_m_di", {24'b0, m_di}, 32'd17);
    check_output("write_m_addr", {24'b0, m_addr}, 32'd5);
    finish(1'b1);
    expect_resp(1'b1, 8'd17);
    apply_stimulus(1'b1, 8'd5, 1'b0, 8'd0);
    check_output("write_a_do_held", {24'b0, a_do}, 32'd42);

    // Contention from reset: A first, then B after RESP and one IDLE cycle
    do_reset();
    expect_resp(1'b0, 8'd10);
    expect_resp(1'b1, 8'd20);
    issue_both(8'd1, 8'd2);
    finish(1'b0);
    check_output("cont_resp_m_valid", {31'b0, m_valid}, 32'd0);
    @(negedge clk);
    check_output("cont_idle_m_valid", {31'b0, m_valid}, 32'd0);
    @(negedge clk);
    check_output("cont_b_m_valid", {31'b0, m_valid}, 32'd1);
    check_output("cont_b_m_addr", {24'b0, m_addr}, 32'd2);
    finish(1'b1);

    // Fairness: both re-request continuously, grants alternate A,B,A,B,A,B
    do_reset();
    a_pulses = 0; b_pulses = 0;
    expect_resp(1'b0, 8'd10);
    expect_resp(1'b1, 8'd20);
    expect_resp(1'b0, 8'd42);
    expect_resp(1'b1, 8'd17);
    expect_resp(1'b0, 8'd10);
    expect_resp(1'b1, 8'd20);
    fork
      begin
        apply_stimulus(1'b0, 8'd1, 1'b0, 8'd0);
        apply_stimulus(1'b0, 8'd3, 1'b0, 8'd0);
        apply_stimulus(1'b0, 8'd1, 1'b0, 8'd0);
      end
      begin
        apply_stimulus(1'b1, 8'd2, 1'b0, 8'd0);
        apply_stimulus(1'b1, 8'd5, 1'b0, 8'd0);
        apply_stimulus(1'b1, 8'd2, 1'b0, 8'd0);
      end
    join
    @(negedge clk);
    check_output("fair_a_pulses", a_pulses, 32'd3);
    check_output("fair_b_pulses", b_pulses, 32'd3);

    // Slow memory: request held stable until the late ready
    mem_delay = 5;
    expect_resp(1'b0, 8'h5A);
    issue(1'b0, 8'd7, 1'b1, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("slow_m_valid", {31'b0, m_valid}, 32'd1);
      check_output("slow_m_addr", {24'b0, m_addr}, 32'd7);
      check_output("slow_m_we", {31'b0, m_we}, 32'd1);
      check_output("slow_m_di", {24'b0, m_di}, 32'h5A);
      check_output("slow_no_ready", {31'b0, a_ready | b_ready}, 32'd0);
    end
    finish(1'b0);

    // Reset in the middle of a slow access drops it without a ready
    issue(1'b0, 8'd3, 1'b0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check_output("midrst_m_valid", {31'b0, m_valid}, 32'd0);
    check_output("midrst_a_ready", {31'b0, a_ready}, 32'd0);
    check_output("midrst_a_do", {24'b0, a_do}, 32'd0);
    check_output("midrst_m_addr", {24'b0, m_addr}, 32'd0);
    a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    mem_delay = 1;
    // prio must be back at A, so A wins the tie
    expect_resp(1'b0, 8'd42);
    expect_resp(1'b1, 8'd20);
    issue_both(8'd3, 8'd2);
    finish(1'b0);
    finish(1'b1);
    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
